// File: rtl/vc_writeback_engine.sv
`default_nettype none
// ============================================================================
// Module   : vc_writeback_engine
// Purpose  : Drains one victim-cache way: tag lookup, line read, memory
//            write burst of dirty lines, then invalidate of the way.
// Revision : 1.0
// ============================================================================
module vc_writeback_engine #(
    parameter int TAG_WIDTH  = 20,
    parameter int NUM_WAYS   = 4,
    parameter int LINE_WORDS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    localparam int WAY_BITS    = $clog2(NUM_WAYS),
    localparam int WORD_BITS   = $clog2(LINE_WORDS),
    localparam int OFFSET_BITS = $clog2(LINE_WORDS * DATA_WIDTH / 8)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_req_valid,
    input  logic [WAY_BITS-1:0]   wb_req_way,
    output logic                  wb_req_ready,
    output logic                  wb_done,
    output logic                  wb_wrote,
    output logic                  busy,
    output logic                  ts_read_en,
    output logic [WAY_BITS-1:0]   ts_read_way,
    input  logic [TAG_WIDTH-1:0]  ts_tag_read,
    input  logic                  ts_dirty_read,
    input  logic                  ts_valid_read,
    output logic                  ts_inv_en,
    output logic [WAY_BITS-1:0]   ts_inv_way,
    output logic                  dr_en,
    output logic [WAY_BITS-1:0]   dr_way,
    output logic [WORD_BITS-1:0]  dr_word,
    input  logic [DATA_WIDTH-1:0] dr_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wlast,
    input  logic                  mem_ack
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_FILL     = 3'd2,
        S_SEND     = 3'd3,
        S_WAIT_ACK = 3'd4,
        S_INVAL    = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    localparam logic [WORD_BITS:0]   c_CNT_ONE      = (WORD_BITS+1)'(1);
    localparam logic [WORD_BITS:0]   c_FILL_LAST    = (WORD_BITS+1)'(LINE_WORDS);
    localparam logic [WORD_BITS:0]   c_FILL_RD_LAST = (WORD_BITS+1)'(LINE_WORDS - 1);
    localparam logic [WORD_BITS-1:0] c_BEAT_ONE     = WORD_BITS'(1);
    localparam logic [WORD_BITS-1:0] c_BEAT_LAST    = WORD_BITS'(LINE_WORDS - 1);

    state_t                r_state;
    logic [WAY_BITS-1:0]   r_way;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic                  r_dirty;
    logic [WORD_BITS:0]    r_cnt;
    logic [WORD_BITS-1:0]  r_beat;
    logic [DATA_WIDTH-1:0] r_line [LINE_WORDS];

    logic                  r_req_ready;
    logic                  r_done;
    logic                  r_wrote;
    logic                  r_busy;
    logic                  r_ts_read_en;
    logic                  r_ts_inv_en;
    logic                  r_dr_en;
    logic [WORD_BITS-1:0]  r_dr_word;
    logic                  r_mem_valid;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_mem_wlast;

    logic [WORD_BITS-1:0]  w_cap_idx;
    logic [WORD_BITS-1:0]  w_next_beat;
    logic [ADDR_WIDTH-1:0] w_line_addr;

    // FILL cycle k captures the word requested on cycle k-1
    assign w_cap_idx   = WORD_BITS'(r_cnt - c_CNT_ONE);
    assign w_next_beat = r_beat + c_BEAT_ONE;
    assign w_line_addr = ADDR_WIDTH'({r_tag, {OFFSET_BITS{1'b0}}});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_way        <= '0;
            r_tag        <= '0;
            r_dirty      <= 1'b0;
            r_cnt        <= '0;
            r_beat       <= '0;
            r_req_ready  <= 1'b1;
            r_done       <= 1'b0;
            r_wrote      <= 1'b0;
            r_busy       <= 1'b0;
            r_ts_read_en <= 1'b0;
            r_ts_inv_en  <= 1'b0;
            r_dr_en      <= 1'b0;
            r_dr_word    <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_wdata  <= '0;
            r_mem_wlast  <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_line[i] <= '0;
            end
        end else begin
            r_ts_read_en <= 1'b0;
            r_ts_inv_en  <= 1'b0;
            r_dr_en      <= 1'b0;
            r_dr_word    <= '0;
            r_done       <= 1'b0;
            r_wrote      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wb_req_valid) begin
                        r_way        <= wb_req_way;
                        r_ts_read_en <= 1'b1;
                        r_req_ready  <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    r_tag   <= ts_tag_read;
                    r_dirty <= ts_dirty_read;
                    if (!ts_valid_read) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (!ts_dirty_read) begin
                        r_ts_inv_en <= 1'b1;
                        r_done      <= 1'b1;
                        r_state     <= S_INVAL;
                    end else begin
                        r_dr_en <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (r_cnt != '0) begin
                        r_line[w_cap_idx] <= dr_data;
                    end
                    if (r_cnt < c_FILL_RD_LAST) begin
                        r_dr_en   <= 1'b1;
                        r_dr_word <= WORD_BITS'(r_cnt + c_CNT_ONE);
                    end
                    if (r_cnt == c_FILL_LAST) begin
                        r_cnt       <= '0;
                        r_beat      <= '0;
                        r_mem_valid <= 1'b1;
                        r_mem_wdata <= r_line[0];
                        r_mem_wlast <= 1'b0;
                        r_state     <= S_SEND;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_SEND: begin
                    // Beat registers only move on a handshake, which keeps them stable under stall
                    if (mem_req_ready) begin
                        if (r_beat == c_BEAT_LAST) begin
                            r_mem_valid <= 1'b0;
                            r_mem_wlast <= 1'b0;
                            r_mem_wdata <= '0;
                            r_state     <= S_WAIT_ACK;
                        end else begin
                            r_beat      <= w_next_beat;
                            r_mem_wdata <= r_line[w_next_beat];
                            r_mem_wlast <= (w_next_beat == c_BEAT_LAST);
                        end
                    end
                end
                S_WAIT_ACK: begin
                    if (mem_ack) begin
                        r_ts_inv_en <= 1'b1;
                        r_done      <= 1'b1;
                        r_wrote     <= r_dirty;
                        r_state     <= S_INVAL;
                    end
                end
                S_INVAL, S_DONE: begin
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wb_req_ready  = r_req_ready;
    assign wb_done       = r_done;
    assign wb_wrote      = r_wrote;
    assign busy          = r_busy;
    assign ts_read_en    = r_ts_read_en;
    assign ts_read_way   = r_ts_read_en ? r_way : '0;
    assign ts_inv_en     = r_ts_inv_en;
    assign ts_inv_way    = r_ts_inv_en ? r_way : '0;
    assign dr_en         = r_dr_en;
    assign dr_way        = r_dr_en ? r_way : '0;
    assign dr_word       = r_dr_word;
    assign mem_req_valid = r_mem_valid;
    assign mem_addr      = r_mem_valid ? w_line_addr : '0;
    assign mem_wdata     = r_mem_wdata;
    assign mem_wlast     = r_mem_wlast;

endmodule
`default_nettype wire

// File: tb/tb_vc_writeback_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_vc_writeback_engine
// Purpose  : Self-checking bench for vc_writeback_engine (tables, corner
//            sequences and randomized requests against a timing model).
// Revision : 1.0
// ============================================================================
module tb_vc_writeback_engine;

    localparam int TW = 20;
    localparam int NW = 4;
    localparam int LW = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    localparam logic [127:0] c_RST_OUTS = {47'd0, 1'b1, 80'd0};

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_req_valid;
    logic [1:0]    wb_req_way;
    logic          wb_req_ready, wb_done, wb_wrote, busy;
    logic          ts_read_en;
    logic [1:0]    ts_read_way;
    logic [TW-1:0] ts_tag_read;
    logic          ts_dirty_read, ts_valid_read;
    logic          ts_inv_en;
    logic [1:0]    ts_inv_way;
    logic          dr_en;
    logic [1:0]    dr_way, dr_word;
    logic [DW-1:0] dr_data;
    logic          mem_req_valid, mem_req_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wlast, mem_ack;

    logic [TW-1:0] m_tag   [NW];
    logic          m_valid [NW];
    logic          m_dirty [NW];
    logic [DW-1:0] m_data  [NW][LW];

    int n_tests = 0;
    int n_fail  = 0;

    vc_writeback_engine #(
        .TAG_WIDTH(TW), .NUM_WAYS(NW), .LINE_WORDS(LW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_req_valid(wb_req_valid), .wb_req_way(wb_req_way), .wb_req_ready(wb_req_ready),
        .wb_done(wb_done), .wb_wrote(wb_wrote), .busy(busy),
        .ts_read_en(ts_read_en), .ts_read_way(ts_read_way),
        .ts_tag_read(ts_tag_read), .ts_dirty_read(ts_dirty_read), .ts_valid_read(ts_valid_read),
        .ts_inv_en(ts_inv_en), .ts_inv_way(ts_inv_way),
        .dr_en(dr_en), .dr_way(dr_way), .dr_word(dr_word), .dr_data(dr_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wlast(mem_wlast), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Tag store reads combinationally, data array one cycle after the enable
    assign ts_tag_read   = m_tag[ts_read_way];
    assign ts_valid_read = m_valid[ts_read_way];
    assign ts_dirty_read = m_dirty[ts_read_way];
    always @(posedge clk) dr_data <= dr_en ? m_data[dr_way][dr_word] : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return {47'd0, wb_req_ready, wb_done, wb_wrote, busy, ts_read_en, ts_read_way,
                ts_inv_en, ts_inv_way, dr_en, dr_way, dr_word, mem_req_valid,
                mem_addr, mem_wdata, mem_wlast};
    endfunction

    // One request; cycle n counts from the accepting edge (n=1 is LOOKUP).
    task automatic run_req(input int way, input int sb, input int sc, input int ad, input bit spur,
                           output int o_done, output int o_wrote, output int o_beats);
        int m_done, m_nb, m_inv, m_wrote;
        int            beat_cyc [$];
        logic [AW-1:0] beat_addr[$];
        logic [DW-1:0] beat_data[$];
        logic          beat_last[$];
        int inv_cnt = 0, inv_cyc = -1, inv_way = -1;
        int hold_err = 0, busy_err = 0, ack_cyc = -1, stall_left = sc;
        bit prev_stall = 1'b0, fin = 1'b0;
        logic [AW-1:0] p_addr = '0;
        logic [DW-1:0] p_data = '0;
        logic          p_last = 1'b0;

        if (!m_valid[way]) begin
            m_done = 2; m_nb = 0; m_inv = 0; m_wrote = 0;
        end else if (!m_dirty[way]) begin
            m_done = 2; m_nb = 0; m_inv = 1; m_wrote = 0;
        end else begin
            m_nb = LW; m_inv = 1; m_wrote = 1;
            m_done = (3 + LW) + (LW - 1) + sc + ad + 1;
        end
        o_done = -1; o_wrote = 0;

        @(negedge clk);
        chk("req_ready_idle", 128'(wb_req_ready), 128'(1));
        wb_req_valid = 1'b1;
        wb_req_way   = 2'(way);
        for (int n = 1; n <= 300 && !fin; n++) begin
            @(negedge clk);
            wb_req_valid  = 1'b0;
            mem_ack       = (n == ack_cyc) || (spur && n == 3);
            mem_req_ready = !(mem_req_valid && beat_cyc.size() == sb && stall_left > 0);
            if (mem_req_valid && !mem_req_ready) stall_left--;
            if (prev_stall && (!mem_req_valid || mem_addr !== p_addr || mem_wdata !== p_data
                               || mem_wlast !== p_last)) hold_err++;
            prev_stall = mem_req_valid && !mem_req_ready;
            p_addr = mem_addr; p_data = mem_wdata; p_last = mem_wlast;
            if (mem_req_valid && mem_req_ready) begin
                beat_cyc.push_back(n);
                beat_addr.push_back(mem_addr);
                beat_data.push_back(mem_wdata);
                beat_last.push_back(mem_wlast);
                if (mem_wlast) ack_cyc = n + ad;
            end
            if (ts_inv_en) begin
                inv_cnt++; inv_cyc = n; inv_way = int'(ts_inv_way);
            end
            if (wb_done) begin
                o_done = n; o_wrote = int'(wb_wrote);
            end
            if (o_done < 0 || n <= o_done) begin
                if (!busy || wb_req_ready) busy_err++;
            end else begin
                chk("ready_after_done", 128'(wb_req_ready), 128'(1));
                fin = 1'b1;
            end
        end
        mem_ack = 1'b0;
        mem_req_ready = 1'b1;
        o_beats = beat_cyc.size();

        chk("finished_in_budget", 128'(fin), 128'(1));
        chk("done_cycle", 128'(o_done), 128'(m_done));
        chk("wrote", 128'(o_wrote), 128'(m_wrote));
        chk("inv_count", 128'(inv_cnt), 128'(m_inv));
        if (m_inv != 0) begin
            chk("inv_way", 128'(inv_way), 128'(way));
            chk("inv_cycle", 128'(inv_cyc), 128'(m_done));
        end
        chk("beat_count", 128'(o_beats), 128'(m_nb));
        for (int i = 0; i < o_beats && i < m_nb; i++) begin
            chk("beat_cyc_addr_data_last",
                128'({beat_cyc[i], beat_addr[i], beat_data[i], beat_last[i]}),
                128'({32'(3 + LW + i + ((i >= sb) ? sc : 0)), AW'({m_tag[way], 4'b0000}),
                      m_data[way][i], 1'(i == LW - 1)}));
        end
        chk("beat_hold", 128'(hold_err), 128'(0));
        chk("busy_ready_while_active", 128'(busy_err), 128'(0));
    endtask

    typedef struct {
        int         way;
        bit         v;
        bit         d;
        logic [TW-1:0] tag;
        int         sb;
        int         sc;
        int         ad;
        bit         spur;
        int         e_done;
        int         e_wrote;
        int         e_beats;
    } vec_t;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        int od, ow, ob, ev;

        rst = 1'b1; wb_req_valid = 1'b0; wb_req_way = '0;
        mem_req_ready = 1'b1; mem_ack = 1'b0;
        for (int w = 0; w < NW; w++) begin
            m_tag[w] = '0; m_valid[w] = 1'b0; m_dirty[w] = 1'b0;
            for (int k = 0; k < LW; k++) m_data[w][k] = $urandom;
        end
        m_data[3][0] = 32'h11; m_data[3][1] = 32'h22;
        m_data[3][2] = 32'h33; m_data[3][3] = 32'h44;

        vecs[0] = '{2, 1'b0, 1'b0, 20'h00000, 0, 0,  1, 1'b0,  2, 0, 0};
        vecs[1] = '{1, 1'b1, 1'b0, 20'h12345, 0, 0,  1, 1'b0,  2, 0, 0};
        vecs[2] = '{3, 1'b1, 1'b1, 20'hABCDE, 0, 0,  1, 1'b0, 12, 1, 4};
        vecs[3] = '{3, 1'b1, 1'b1, 20'hABCDE, 2, 3,  1, 1'b0, 15, 1, 4};
        vecs[4] = '{3, 1'b1, 1'b1, 20'hABCDE, 0, 0, 10, 1'b1, 21, 1, 4};

        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), c_RST_OUTS);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            m_valid[vecs[i].way] = vecs[i].v;
            m_dirty[vecs[i].way] = vecs[i].d;
            m_tag[vecs[i].way]   = vecs[i].tag;
            run_req(vecs[i].way, vecs[i].sb, vecs[i].sc, vecs[i].ad, vecs[i].spur, od, ow, ob);
            chk("vec_done", 128'(od), 128'(vecs[i].e_done));
            chk("vec_wrote", 128'(ow), 128'(vecs[i].e_wrote));
            chk("vec_beats", 128'(ob), 128'(vecs[i].e_beats));
        end

        // Reset while beat 1 is on the bus, then a fresh request
        m_valid[3] = 1'b1; m_dirty[3] = 1'b1; m_tag[3] = 20'hABCDE;
        @(negedge clk);
        wb_req_valid = 1'b1; wb_req_way = 2'd3;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            wb_req_valid = 1'b0;
        end
        chk("rst_seq_beat1", 128'({mem_req_valid, mem_wdata}), 128'({1'b1, 32'h22}));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_outputs", outs(), c_RST_OUTS);
        ev = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (wb_done || ts_inv_en || mem_req_valid || busy) ev++;
        end
        chk("rst_mid_quiet", 128'(ev), 128'(0));
        run_req(3, 0, 0, 1, 1'b0, od, ow, ob);

        for (int r = 0; r < 20; r++) begin
            int way;
            way = int'($urandom_range(0, NW - 1));
            m_valid[way] = 1'($urandom_range(0, 1));
            m_dirty[way] = 1'($urandom_range(0, 1));
            m_tag[way]   = TW'($urandom);
            for (int k = 0; k < LW; k++) m_data[way][k] = $urandom;
            run_req(way, int'($urandom_range(0, LW - 1)), int'($urandom_range(0, 3)),
                    int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), od, ow, ob);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vc_writeback_engine.md
# vc_writeback_engine

Drains one victim-cache way to the next memory level when the victim cache must evict it. On a request naming a way, it reads that way's tag/valid/dirty from the tag store and its line from the data array. A dirty line is written to memory as a burst, and the way is invalidated once the write is acknowledged. It is the read/retire side of the victim-cache install path: L1 evictions write ways in, this block reads them out.

## Interface
- TAG_WIDTH, 20, line tag width, same as victim-cache tag store
- NUM_WAYS, 4, victim-cache ways; WAY_BITS = $clog2(NUM_WAYS)
- LINE_WORDS, 4, data words per line (power of 2, >=2); WORD_BITS = $clog2(LINE_WORDS)
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 32, memory byte-address width; OFFSET_BITS = $clog2(LINE_WORDS*DATA_WIDTH/8); TAG_WIDTH+OFFSET_BITS <= ADDR_WIDTH

- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous reset, active-high
- wb_req_valid  in  1  writeback request
- wb_req_way  in  WAY_BITS  way to drain
- wb_req_ready  out  1  engine idle, request accepted on valid&ready
- wb_done  out  1  one-cycle pulse, request finished
- wb_wrote  out  1  valid with wb_done: 1 = memory burst issued
- busy  out  1  not IDLE
- ts_read_en  out  1  tag-store read enable
- ts_read_way  out  WAY_BITS  tag-store read way
- ts_tag_read / ts_dirty_read / ts_valid_read  in  TAG_WIDTH/1/1  combinational tag-store read data
- ts_inv_en  out  1  tag-store invalidate strobe
- ts_inv_way  out  WAY_BITS  way to invalidate
- dr_en  out  1  data-array read enable
- dr_way  out  WAY_BITS  data-array way
- dr_word  out  WORD_BITS  word within line
- dr_data  in  DATA_WIDTH  read data, valid the cycle after dr_en
- mem_req_valid  out  1  write beat valid
- mem_req_ready  in  1  memory accepts beat
- mem_addr  out  ADDR_WIDTH  line base address, zero-extended {tag, OFFSET_BITS'0}
- mem_wdata  out  DATA_WIDTH  beat data, word 0 first
- mem_wlast  out  1  final beat
- mem_ack  in  1  one-cycle write response

## Operation
- States:
  - IDLE: request accepted; latch way.
  - LOOKUP: one cycle; ts_read_en=1, ts_read_way=latched way; latch tag, valid, dirty.
    - If !valid, go to DONE.
    - If valid && !dirty, go to INVAL.
    - Otherwise go to FILL.
  - FILL: LINE_WORDS+1 cycles; cycle k<LINE_WORDS drives dr_en=1, dr_word=k; dr_data captured into line buffer word k-1 on cycle k≥1. Then go to SEND.
  - SEND: beat counter 0..LINE_WORDS-1; mem_req_valid=1; mem_wlast=1 on final beat; advance on mem_req_valid&&mem_req_ready. After the final handshake, go to WAIT_ACK.
  - WAIT_ACK: hold until mem_ack, then go to INVAL.
  - INVAL: one cycle; ts_inv_en=1, ts_inv_way=latched way; wb_done=1; wb_wrote=1 iff the line was dirty. Go to IDLE.
  - DONE: one cycle; wb_done=1, wb_wrote=0, no invalidate. Go to IDLE.
- Beat hold rules:
  - Once mem_req_valid rises, it must not fall before the handshake.
  - mem_addr, mem_wdata and mem_wlast must stay stable while valid && !ready.
- mem_ack is sampled only in WAIT_ACK and ignored elsewhere. Memory never acks before the cycle after the last beat.
- Integrator guarantees no install or invalidate targets the busy way while busy=1.
- Invalid way: no memory traffic and no invalidate.

## Timing
- Reset values:
  - wb_req_ready=1.
  - All other outputs 0; state IDLE; counters 0.
- Reset mid-operation returns to IDLE next cycle:
  - No invalidate and no wb_done are issued.
  - An in-flight beat is abandoned; the memory side is reset together with this block.
- Request accepted at cycle T:
  - LOOKUP at T+1.
  - Invalid line: DONE at T+2, wb_req_ready=1 at T+3.
  - Clean line: INVAL at T+2, wb_req_ready=1 at T+3.
  - Dirty line: FILL at T+2..T+2+LINE_WORDS; first beat at T+3+LINE_WORDS.
- Dirty line, LINE_WORDS=4, ready always high, ack one cycle after last beat:
  - Beats at T+7..T+10.
  - Ack at T+11.
  - INVAL/done at T+12.
  - wb_req_ready=1 at T+13.
- Back-to-back requests: a new request is accepted the first IDLE cycle. There is no request queue; wb_req_ready=0 whenever busy.

## Test plan
- Reset, then request way 2, which is invalid -> wb_done and wb_wrote=0 at T+2; ts_inv_en is never asserted; mem_req_valid is never asserted.
- Way 1 valid, clean, tag 0x12345 -> ts_inv_en=1 with ts_inv_way=1 at T+2, together with wb_done=1 and wb_wrote=0; no memory beats.
- Way 3 dirty, tag 0xABCDE, data words 0x11,0x22,0x33,0x44, mem_req_ready=1, ack at T+11:
  - Beats at T+7..T+10 with mem_addr=0x00ABCDE0 and data 0x11..0x44 in order.
  - mem_wlast=1 only at T+10.
  - Invalidate of way 3 and done (wb_wrote=1) at T+12.
- Same dirty line, mem_req_ready low for 3 cycles on beat 2 -> beat 2 is held stable with valid high throughout; total latency grows by exactly 3 cycles.
- Dirty writeback with ack delayed 10 cycles -> state stays WAIT_ACK and busy=1; the invalidate follows the ack by exactly one cycle. A spurious mem_ack pulsed during FILL is ignored.
- Assert rst during SEND beat 1 -> next cycle: IDLE, wb_req_ready=1, all other outputs 0, no wb_done. A fresh request then completes normally.
